// File: rtl/ctrl_layer_seq_pkg.sv
// Shared types and defaults for the conv-layer sequencer.
package ctrl_layer_seq_pkg;

  localparam int unsigned MNV_DEF   = 224 * 224;
  localparam int unsigned TMO_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_FINISH = 3'd5,
    ST_ABORT  = 3'd6
  } state_e;

endpackage

// File: rtl/ctrl_tmo_cnt.sv
// Per-volume watchdog: reloads on load, counts down otherwise, flags the last
// permitted cycle. A limit of zero never expires.
module ctrl_tmo_cnt #(
  parameter int unsigned TMO_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [TMO_W-1:0] lim,
  output logic             expired
);

  logic [TMO_W-1:0] cnt;

  // Down-counter; expired is registered so it is high while cnt == 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (load) begin
      cnt     <= lim;
      expired <= (lim == TMO_W'(1));
    end else if (cnt != '0) begin
      cnt     <= cnt - TMO_W'(1);
      expired <= (cnt == TMO_W'(2));
    end else begin
      expired <= 1'b0;
    end
  end

endmodule

// File: rtl/ctrl_layer_seq.sv
// Conv-layer sequencer: steps the datapath through num_vol volumes, driving
// the external volume counter and guarding each volume with a watchdog.
module ctrl_layer_seq
  import ctrl_layer_seq_pkg::*;
#(
  parameter int unsigned MNV   = MNV_DEF,
  parameter int unsigned TMO_W = TMO_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [$clog2(MNV)-1:0] num_vol,
  input  logic [TMO_W-1:0]       tmo_lim,
  input  logic                   dp_done,
  input  logic                   op_done,
  output logic                   vol_start,
  output logic                   cnt_clear_vol,
  output logic                   cnt_load,
  output logic                   cnt_in_vol,
  output logic [$clog2(MNV)-1:0] max_val,
  output logic [$clog2(MNV)-1:0] vol_idx,
  output logic                   busy,
  output logic                   layer_done,
  output logic                   err
);

  localparam int unsigned VW = $clog2(MNV);

  state_e           state;
  logic [TMO_W-1:0] tmo_lim_q;
  logic             tmo_load;
  logic             tmo_expired;
  logic [VW-1:0]    idx_inc;

  // Watchdog is armed while issuing so it starts at tmo_lim on the first WAIT cycle.
  assign tmo_load = (state == ST_ISSUE);

  // Defensive wrap of the volume index at the last legal volume.
  assign idx_inc = (vol_idx == VW'(MNV - 1)) ? '0 : vol_idx + VW'(1);

  ctrl_tmo_cnt #(
    .TMO_W (TMO_W)
  ) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmo_load),
    .lim     (tmo_lim_q),
    .expired (tmo_expired)
  );

  // Sequencer FSM; every output is registered alongside the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      tmo_lim_q     <= '0;
      max_val       <= '0;
      vol_idx       <= '0;
      vol_start     <= 1'b0;
      cnt_clear_vol <= 1'b0;
      cnt_load      <= 1'b0;
      cnt_in_vol    <= 1'b0;
      busy          <= 1'b0;
      layer_done    <= 1'b0;
      err           <= 1'b0;
    end else begin
      vol_start     <= 1'b0;
      cnt_clear_vol <= 1'b0;
      cnt_load      <= 1'b0;
      cnt_in_vol    <= 1'b0;
      layer_done    <= 1'b0;
      err           <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (num_vol != '0) begin
              state         <= ST_CLEAR;
              max_val       <= num_vol;
              tmo_lim_q     <= tmo_lim;
              cnt_clear_vol <= 1'b1;
              busy          <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_CLEAR: begin
          state    <= ST_LOAD;
          cnt_load <= 1'b1;
          vol_idx  <= '0;
        end
        ST_LOAD: begin
          state     <= ST_ISSUE;
          vol_start <= 1'b1;
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // Completion in the expiry cycle takes priority over the watchdog.
          if (dp_done) begin
            state <= ST_FINISH;
          end else if (tmo_expired) begin
            state         <= ST_ABORT;
            cnt_clear_vol <= 1'b1;
            err           <= 1'b1;
          end
        end
        ST_FINISH: begin
          // op_done has had the full FINISH->ISSUE->WAIT loop to settle.
          if (op_done) begin
            state      <= ST_IDLE;
            layer_done <= 1'b1;
            busy       <= 1'b0;
          end else begin
            state      <= ST_ISSUE;
            vol_start  <= 1'b1;
            cnt_in_vol <= 1'b1;
            vol_idx    <= idx_inc;
          end
        end
        ST_ABORT: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_layer_seq.sv
// Directed bench for ctrl_layer_seq with an attached volume-counter model.
module tb_ctrl_layer_seq;

  localparam int unsigned VW    = $clog2(224 * 224);
  localparam int unsigned TMO_W = 16;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [VW-1:0]    num_vol;
  logic [TMO_W-1:0] tmo_lim;
  logic             dp_done;
  logic             op_done;
  logic             vol_start;
  logic             cnt_clear_vol;
  logic             cnt_load;
  logic             cnt_in_vol;
  logic [VW-1:0]    max_val;
  logic [VW-1:0]    vol_idx;
  logic             busy;
  logic             layer_done;
  logic             err;

  int checks   = 0;
  int failures = 0;

  int            n_vs, n_inc, n_done, n_err, n_excl, busy_at_done, timed_out;
  logic [VW-1:0] idx_seen [8];

  ctrl_layer_seq dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .num_vol       (num_vol),
    .tmo_lim       (tmo_lim),
    .dp_done       (dp_done),
    .op_done       (op_done),
    .vol_start     (vol_start),
    .cnt_clear_vol (cnt_clear_vol),
    .cnt_load      (cnt_load),
    .cnt_in_vol    (cnt_in_vol),
    .max_val       (max_val),
    .vol_idx       (vol_idx),
    .busy          (busy),
    .layer_done    (layer_done),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Volume counter model: op_done is the registered "last volume reached" flag.
  logic [VW-1:0] m_cnt;
  logic [VW-1:0] m_nx;
  always_comb begin
    m_nx = m_cnt;
    if (cnt_clear_vol || cnt_load) m_nx = '0;
    else if (cnt_in_vol)           m_nx = m_cnt + VW'(1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt   <= '0;
      op_done <= 1'b0;
    end else begin
      m_cnt   <= m_nx;
      op_done <= (m_nx == max_val - VW'(1));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs a layer from the ISSUE of volume 0 until layer_done/err or budget.
  task automatic run_layer(input int dly, input bit noise, input int budget);
    int  cd;
    bit  fin_next;
    bit  done;
    cd = -1; fin_next = 1'b0; done = 1'b0;
    n_vs = 0; n_inc = 0; n_done = 0; n_err = 0; n_excl = 0;
    busy_at_done = -1; timed_out = 0;
    for (int c = 0; c < budget && !done; c++) begin
      tick;
      dp_done = 1'b0;
      if (noise) begin
        start   = 1'b1;
        num_vol = VW'(7);
        if (fin_next) dp_done = 1'b1;
      end
      fin_next = 1'b0;
      if (vol_start) begin
        if (n_vs < 8) idx_seen[n_vs] = vol_idx;
        n_vs++;
        cd = dly;
        if (noise) dp_done = 1'b1;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          dp_done  = 1'b1;
          fin_next = 1'b1;
        end
      end
      if (int'(cnt_clear_vol) + int'(cnt_load) + int'(cnt_in_vol) > 1) n_excl++;
      if (cnt_in_vol) n_inc++;
      if (err) begin n_err++; done = 1'b1; end
      if (layer_done) begin
        n_done++;
        busy_at_done = int'(busy);
        done  = 1'b1;
        start = 1'b0;
      end
    end
    if (!done) timed_out = 1;
    dp_done = 1'b0;
    start   = 1'b0;
  endtask

  // Global time bound so the bench can never hang.
  initial begin
    #400000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; num_vol = '0; tmo_lim = '0; dp_done = 1'b0;
    tick; tick;
    chk("rst_busy", busy, 0);
    chk("rst_vol_start", vol_start, 0);
    chk("rst_cnt_clear", cnt_clear_vol, 0);
    chk("rst_max_val", max_val, 0);
    chk("rst_vol_idx", vol_idx, 0);

    // Start present in the very first cycle after release; 3 volumes.
    start = 1'b1; num_vol = VW'(3); tmo_lim = '0;
    @(negedge clk); rst_n = 1'b1;
    tick;
    start = 1'b0;
    chk("l3_clear", cnt_clear_vol, 1);
    chk("l3_busy", busy, 1);
    chk("l3_max_val", max_val, 3);
    tick;
    chk("l3_load", cnt_load, 1);
    chk("l3_load_idx", vol_idx, 0);
    run_layer(2, 1'b0, 200);
    chk("l3_timeout", timed_out, 0);
    chk("l3_vol_starts", n_vs, 3);
    chk("l3_in_vol", n_inc, 2);
    chk("l3_done", n_done, 1);
    chk("l3_err", n_err, 0);
    chk("l3_idx0", idx_seen[0], 0);
    chk("l3_idx1", idx_seen[1], 1);
    chk("l3_idx2", idx_seen[2], 2);
    chk("l3_busy_at_done", busy_at_done, 0);
    chk("l3_excl", n_excl, 0);
    tick;
    chk("l3_done_single", layer_done, 0);

    // Single volume, stepped state by state.
    start = 1'b1; num_vol = VW'(1);
    tick; start = 1'b0;
    chk("l1_clear", cnt_clear_vol, 1);
    tick;
    chk("l1_load", cnt_load, 1);
    tick;
    chk("l1_issue", vol_start, 1);
    chk("l1_issue_idx", vol_idx, 0);
    tick;
    chk("l1_wait_vs", vol_start, 0);
    chk("l1_wait_busy", busy, 1);
    dp_done = 1'b1;
    tick; dp_done = 1'b0;
    chk("l1_finish_busy", busy, 1);
    chk("l1_finish_done", layer_done, 0);
    tick;
    chk("l1_layer_done", layer_done, 1);
    chk("l1_no_in_vol", cnt_in_vol, 0);
    chk("l1_idle_busy", busy, 0);

    // Zero-volume start is rejected.
    start = 1'b1; num_vol = '0;
    tick; start = 1'b0;
    chk("z_err", err, 1);
    chk("z_busy", busy, 0);
    chk("z_clear", cnt_clear_vol, 0);
    chk("z_load", cnt_load, 0);
    tick;
    chk("z_err_single", err, 0);
    chk("z_busy2", busy, 0);

    // Watchdog of 4 with dp_done withheld.
    start = 1'b1; num_vol = VW'(3); tmo_lim = TMO_W'(4);
    tick; start = 1'b0;
    tick;
    tick;
    chk("wd_issue", vol_start, 1);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("wd_wait_busy", busy, 1);
      chk("wd_wait_err", err, 0);
      chk("wd_wait_clear", cnt_clear_vol, 0);
    end
    tick;
    chk("wd_abort_err", err, 1);
    chk("wd_abort_clear", cnt_clear_vol, 1);
    tick;
    chk("wd_idle_busy", busy, 0);
    chk("wd_idle_err", err, 0);
    start = 1'b1; num_vol = VW'(2); tmo_lim = TMO_W'(4);
    tick; start = 1'b0;
    tick;
    run_layer(2, 1'b0, 200);
    chk("wd2_timeout", timed_out, 0);
    chk("wd2_vol_starts", n_vs, 2);
    chk("wd2_in_vol", n_inc, 1);
    chk("wd2_done", n_done, 1);
    chk("wd2_err", n_err, 0);

    // Reset dropped in WAIT of volume index 1 of a 5-volume layer.
    start = 1'b1; num_vol = VW'(5); tmo_lim = '0;
    tick; start = 1'b0;
    tick;
    tick;
    tick;
    dp_done = 1'b1;
    tick; dp_done = 1'b0;
    tick;
    chk("rm_issue1", vol_start, 1);
    chk("rm_in_vol", cnt_in_vol, 1);
    chk("rm_idx1", vol_idx, 1);
    tick;
    chk("rm_wait_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rm_busy", busy, 0);
    chk("rm_vol_idx", vol_idx, 0);
    chk("rm_max_val", max_val, 0);
    chk("rm_pulses", {vol_start, cnt_clear_vol, cnt_load, cnt_in_vol, layer_done, err}, 0);
    @(negedge clk);
    start = 1'b1; num_vol = VW'(2);
    @(negedge clk); rst_n = 1'b1;
    tick; start = 1'b0;
    chk("rm2_clear", cnt_clear_vol, 1);
    tick;
    run_layer(2, 1'b0, 200);
    chk("rm2_timeout", timed_out, 0);
    chk("rm2_vol_starts", n_vs, 2);
    chk("rm2_done", n_done, 1);

    // Spurious start / dp_done while busy are ignored.
    start = 1'b1; num_vol = VW'(4);
    tick;
    num_vol = VW'(7); dp_done = 1'b1;
    tick;
    chk("nz_load", cnt_load, 1);
    chk("nz_max_val", max_val, 4);
    run_layer(2, 1'b1, 300);
    chk("nz_timeout", timed_out, 0);
    chk("nz_vol_starts", n_vs, 4);
    chk("nz_in_vol", n_inc, 3);
    chk("nz_done", n_done, 1);
    chk("nz_err", n_err, 0);
    chk("nz_idx3", idx_seen[3], 3);
    chk("nz_excl", n_excl, 0);
    tick;
    chk("nz_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ctrl_layer_seq.md
CTRL_LAYER_SEQ -- requirements
Module: ctrl_layer_seq

Interface
REQ-001 Parameter MNV, default 224*224: maximum number of conv volumes per layer.
REQ-002 Parameter TMO_W, default 16: width of the per-volume watchdog limit.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  layer start request, sampled only in IDLE.
REQ-006 num_vol  input  $clog2(MNV)  number of conv volumes in the layer, sampled with start.
REQ-007 tmo_lim  input  TMO_W  max cycles to wait for dp_done per volume, sampled with start; 0 disables the watchdog.
REQ-008 dp_done  input  1  datapath single-cycle pulse: current volume computed.
REQ-009 op_done  input  1  registered "last volume reached" flag from the volume counter.
REQ-010 vol_start  output  1  single-cycle pulse: datapath begins the next volume.
REQ-011 cnt_clear_vol  output  1  volume counter clear pulse.
REQ-012 cnt_load  output  1  volume counter load pulse.
REQ-013 cnt_in_vol  output  1  volume counter advance pulse.
REQ-014 max_val  output  $clog2(MNV)  terminal count for the volume counter.
REQ-015 vol_idx  output  $clog2(MNV)  zero-based index of the volume in flight.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 layer_done  output  1  single-cycle pulse: layer completed normally.
REQ-018 err  output  1  single-cycle pulse: start rejected or watchdog expired.

Function
REQ-019 FSM states SHALL be IDLE, CLEAR, LOAD, ISSUE, WAIT, FINISH and ABORT, one state per cycle except WAIT.
REQ-020 IDLE: start=1 with num_vol!=0 -> latch num_vol and tmo_lim, go to CLEAR; start=1 with num_vol==0 -> err pulse, remain in IDLE.
REQ-021 CLEAR SHALL assert cnt_clear_vol, then go to LOAD.
REQ-022 LOAD SHALL assert cnt_load, clear vol_idx to 0, then go to ISSUE.
REQ-023 max_val SHALL equal the latched num_vol from the cycle after start is accepted until the return to IDLE, stable throughout; reset value 0.
REQ-024 ISSUE SHALL assert vol_start, load the watchdog, then go to WAIT.
REQ-025 WAIT: on dp_done go to FINISH; on watchdog expiry (tmo_lim!=0, tmo_lim cycles in WAIT without dp_done) go to ABORT; dp_done in the expiry cycle wins.
REQ-026 FINISH: op_done=1 -> layer_done pulse, go to IDLE; op_done=0 -> assert cnt_in_vol, increment vol_idx, go to ISSUE.
REQ-027 The minimum FINISH->ISSUE->WAIT->FINISH loop of 3 cycles guarantees op_done has settled when FINISH samples it; this loop SHALL NOT be shortened.
REQ-028 ABORT SHALL assert cnt_clear_vol and the err pulse, then go to IDLE.
REQ-029 dp_done outside WAIT SHALL be ignored; start outside IDLE SHALL be ignored.
REQ-030 vol_idx SHALL wrap to 0 if it is incremented past MNV-1 (defensive; unreachable with a correct counter).
REQ-031 All outputs SHALL be registered or decoded from the state register only, with no combinational path from any input to any output.
REQ-032 At most one of cnt_clear_vol, cnt_load and cnt_in_vol SHALL be high in any cycle.

Reset
REQ-033 rst_n low SHALL force IDLE and drive all outputs and internal counters to 0, mid-layer included, without asserting any cnt_* pulse.
REQ-034 The first start after reset release SHALL be honoured if seen in the first clk cycle.

Structure
REQ-035 A shared package SHALL hold the FSM state enum and the MNV default.
REQ-036 The watchdog SHALL be a sub-module ctrl_tmo_cnt with ports clk, rst_n, load, lim and expired, counting down while not loaded.

Verification
REQ-037 num_vol=3, dp_done 2 cycles after each vol_start, counter model attached -> 3 vol_start pulses, 2 cnt_in_vol pulses, vol_idx 0,1,2, one layer_done, busy low the cycle after.
REQ-038 num_vol=1 -> CLEAR, LOAD, ISSUE, WAIT, FINISH sequence, then layer_done with no cnt_in_vol pulse.
REQ-039 start with num_vol=0 -> err pulse next cycle, busy stays 0, no cnt_* pulses.
REQ-040 tmo_lim=4, dp_done withheld -> ABORT after 4 WAIT cycles, then cnt_clear_vol and err pulse, IDLE; a subsequent start of num_vol=2 completes normally.
REQ-041 rst_n dropped in WAIT of volume 2 of 5 -> all outputs 0 immediately; after release, start num_vol=2 -> normal completion.
REQ-042 start pulses and spurious dp_done while busy with num_vol=4 -> ignored; exactly 4 vol_start pulses and one layer_done.
